// File: rtl/dadda_mac_acc.sv
// Dot-product accumulator behind the dadda_8 multiplier: sums LEN unsigned products
// and offers each completed result on a valid/ready port with a sticky wrap flag.
module dadda_mac_acc #(
  parameter int PROD_W = 16,
  parameter int LEN    = 8,
  parameter int ACC_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wrap;
  logic [ACC_W-1:0]   r_acc_data;
  logic               r_acc_ovf;
  logic               r_acc_valid;

  logic               w_beat;
  logic               w_last;
  logic [ACC_W:0]     w_sum;

  assign prod_ready = (r_state != HOLD);
  assign w_beat     = prod_valid & prod_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  // One extra bit so the carry out of this beat is visible for the wrap flag.
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  assign acc_valid  = r_acc_valid;
  assign acc_data   = r_acc_data;
  assign acc_ovf    = r_acc_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (clr) begin
          w_state_next = IDLE;
        end else if (w_beat) begin
          w_state_next = w_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_wrap      <= 1'b0;
      r_acc_data  <= '0;
      r_acc_ovf   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else if (r_state != HOLD) begin
      // A clear wins over a simultaneous beat; that product is dropped.
      if (clr) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_wrap <= 1'b0;
      end else if (w_beat) begin
        if (w_last) begin
          r_acc_data  <= w_sum[ACC_W-1:0];
          r_acc_ovf   <= r_wrap | w_sum[ACC_W];
          r_acc_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_wrap      <= 1'b0;
        end else begin
          r_acc  <= w_sum[ACC_W-1:0];
          r_cnt  <= r_cnt + CNT_W'(1);
          r_wrap <= r_wrap | w_sum[ACC_W];
        end
      end
    end else if (acc_ready) begin
      r_acc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Directed bench for dadda_mac_acc: default LEN=8/ACC_W=19 instance plus a
// LEN=2/ACC_W=16 instance used to exercise the wrap flag.
module tb_dadda_mac_acc;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] prod;
  logic        acc_valid;
  logic        acc_ready;
  logic [18:0] acc_data;
  logic        acc_ovf;

  logic        clr16;
  logic        prod_valid16;
  logic        prod_ready16;
  logic [15:0] prod16;
  logic        acc_valid16;
  logic        acc_ready16;
  logic [15:0] acc_data16;
  logic        acc_ovf16;

  int errors = 0;
  int checks = 0;

  dadda_mac_acc #(.PROD_W(16), .LEN(8), .ACC_W(19)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_ovf    (acc_ovf)
  );

  dadda_mac_acc #(.PROD_W(16), .LEN(2), .ACC_W(16)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr16),
    .prod_valid (prod_valid16),
    .prod_ready (prod_ready16),
    .prod       (prod16),
    .acc_valid  (acc_valid16),
    .acc_ready  (acc_ready16),
    .acc_data   (acc_data16),
    .acc_ovf    (acc_ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the returned negedge sees the posedge result.
  task automatic send(input logic [15:0] v);
    prod_valid = 1'b1;
    prod       = v;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] v);
    prod_valid16 = 1'b1;
    prod16       = v;
    @(negedge clk);
    prod_valid16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;  clr = 1'b0;  prod_valid = 1'b0;  prod = '0;  acc_ready = 1'b1;
    clr16 = 1'b0;  prod_valid16 = 1'b0;  prod16 = '0;  acc_ready16 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(acc_valid), 32'd0);
    check("rst_data",  32'(acc_data),  32'd0);
    check("rst_ovf",   32'(acc_ovf),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_prod_ready", 32'(prod_ready), 32'd1);
    $display("reset released");

    // T1: squares 1..8
    for (int k = 1; k <= 8; k++) send(16'(k * k));
    check("t1_valid", 32'(acc_valid), 32'd1);
    check("t1_data",  32'(acc_data),  32'd204);
    check("t1_ovf",   32'(acc_ovf),   32'd0);
    check("t1_hold_ready", 32'(prod_ready), 32'd0);
    @(negedge clk);
    check("t1_valid_drop", 32'(acc_valid), 32'd0);
    check("t1_ready_back", 32'(prod_ready), 32'd1);
    $display("T1 squares: data=%0d", acc_data);

    // T2: full-scale products
    for (int k = 0; k < 8; k++) send(16'd65025);
    check("t2_valid", 32'(acc_valid), 32'd1);
    check("t2_data",  32'(acc_data),  32'd520200);
    check("t2_ovf",   32'(acc_ovf),   32'd0);
    @(negedge clk);
    $display("T2 max products: data=%0d", acc_data);

    // T3: 16-bit accumulator wraps, then a clean result clears the flag
    send16(16'd65025);
    send16(16'd65025);
    check("t3_valid", 32'(acc_valid16), 32'd1);
    check("t3_data",  32'(acc_data16),  32'd64514);
    check("t3_ovf",   32'(acc_ovf16),   32'd1);
    @(negedge clk);
    send16(16'd1);
    send16(16'd1);
    check("t3b_data", 32'(acc_data16), 32'd2);
    check("t3b_ovf",  32'(acc_ovf16),  32'd0);
    @(negedge clk);
    $display("T3 wrap: data=%0d", acc_data16);

    // T4: backpressure while upstream keeps offering a product
    acc_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(16'd1);
    prod_valid = 1'b1;
    prod       = 16'd77;
    for (int c = 0; c < 5; c++) begin
      check("t4_prod_ready", 32'(prod_ready), 32'd0);
      check("t4_valid",      32'(acc_valid),  32'd1);
      check("t4_data",       32'(acc_data),   32'd8);
      @(negedge clk);
    end
    prod_valid = 1'b0;
    acc_ready  = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", 32'(acc_valid), 32'd0);
    check("t4_ready_back", 32'(prod_ready), 32'd1);
    check("t4_data_kept",  32'(acc_data),  32'd8);
    $display("T4 backpressure: data=%0d", acc_data);

    // T5: clear with a coincident beat, then clear ignored in HOLD
    for (int k = 0; k < 3; k++) send(16'd100);
    clr = 1'b1;
    send(16'd100);
    clr = 1'b0;
    acc_ready = 1'b0;
    for (int k = 0; k < 7; k++) send(16'd3);
    send(16'd5);
    check("t5_data", 32'(acc_data), 32'd26);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5_hold_valid", 32'(acc_valid), 32'd1);
    check("t5_hold_data",  32'(acc_data),  32'd26);
    acc_ready = 1'b1;
    @(negedge clk);
    check("t5_valid_drop", 32'(acc_valid), 32'd0);
    $display("T5 clr: data=%0d", acc_data);

    // T6: asynchronous reset mid-accumulation
    for (int k = 0; k < 5; k++) send(16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(acc_valid), 32'd0);
    check("t6_data",  32'(acc_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_prod_ready", 32'(prod_ready), 32'd1);
    for (int k = 0; k < 8; k++) send(16'd2);
    check("t6_after_valid", 32'(acc_valid), 32'd1);
    check("t6_after_data",  32'(acc_data),  32'd16);
    @(negedge clk);
    $display("T6 reset: data=%0d", acc_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
